fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Packet-aware round-robin write arbiter in front of the shared 9-bit `fifo`. Up to NREQ producers present words with an end-of-packet flag in the MSB. The arbiter grants one producer at a time and holds that grant until the producer's EOP word has been written. It drives the FIFO's `writep`/`data_in` and honours `fullp`, so packets are never interleaved in the FIFO.

## Interface
- NREQ, 4, number of requesters (2..8)
- bitsize, 9, word width; bit [bitsize-1] is EOP, matches `fifo` bitsize
- TIMEOUT, 16, consecutive idle (non-valid, non-stalled) cycles tolerated mid-packet before the grant is revoked
- clk  input  1  rising-edge clock
- rstp  input  1  synchronous active-high reset
- req_valid  input  NREQ  requester i has a word on its data lane
- req_data  input  NREQ*bitsize  flattened lanes; lane i = bits [i*bitsize +: bitsize]
- req_ack  output  NREQ  combinational; word on lane i is written this cycle
- fifo_writep  output  1  combinational; to `fifo.writep`
- fifo_data_in  output  bitsize  combinational; to `fifo.data_in`
- fifo_fullp  input  1  from `fifo.fullp`
- grant_id  output  clog2(NREQ)  registered; current or last granted requester
- busy  output  1  registered; 1 while a grant is held (state BUSY)
- drop_pulse  output  1  registered; one-cycle pulse when a packet is aborted by timeout
- pkt_count  output  16  registered; completed (EOP-written) packets, wraps at 2^16

## Operation
- States: IDLE, BUSY. Round-robin pointer `last` (index of the last served requester).
- IDLE: if any req_valid, select the first set bit searching `last+1, last+2, …` modulo NREQ. Register grant_id, go to BUSY. No word is written in the arbitration cycle.
- BUSY: accept = req_valid[grant_id] & !fifo_fullp. When accept is 1, fifo_writep=1, fifo_data_in=lane grant_id, req_ack[grant_id]=1. All other req_ack bits are 0.
- Accepted word with EOP=1: go to IDLE, last<=grant_id, pkt_count+1. A single-word packet (EOP on the first word) is legal.
- Idle counter: in BUSY, increments when req_valid[grant_id]=0. It is cleared on accept. It holds (does not count) while req_valid=1 and fifo_fullp=1, because a full-FIFO stall is not an idle cycle. When the counter reaches TIMEOUT: go to IDLE, last<=grant_id, drop_pulse=1 for one cycle, pkt_count unchanged. Words already written stay in the FIFO. The producer is responsible for any recovery.
- In IDLE: fifo_writep=0, req_ack=0, fifo_data_in=0.
- Requesters other than grant_id are ignored in BUSY. They keep req_valid asserted and wait.
- Reset (rstp=1 at clk edge) from any state: state IDLE, last=NREQ-1 (requester 0 wins first), grant_id=0, busy=0, drop_pulse=0, pkt_count=0, idle counter=0. Combinational outputs follow IDLE (all 0). Reset mid-packet discards the grant with no drop_pulse.

## Timing
- Arbitration latency: req_valid rising in IDLE at cycle N → busy=1 and grant_id valid at N+1 → first write at N+1 if not full.
- Throughput in BUSY: one word per cycle while valid & !full.
- Packet turnaround: EOP written at cycle M → IDLE at M+1 → next grant at M+2. This gives one bubble cycle between packets.
- Timeout: BUSY with req_valid[grant_id]=0 from cycle K → drop_pulse=1 and busy=0 at K+TIMEOUT.
- fifo_fullp is sampled combinationally. The FIFO must see writep=0 whenever fullp=1.

## Test plan
- Single requester 0 sends a 3-word packet {0x012, 0x034, 0x1AB}, FIFO empty → grant at cycle 1, writes on cycles 1–3, busy=0 at 4, pkt_count=1, FIFO holds 0x012, 0x034, 0x1AB.
- All 4 requesters continuously valid with 2-word packets after reset → grant order 0,1,2,3,0. No interleaving in the FIFO data. pkt_count=5 after 5 packets.
- FIFO pre-filled to 255 words, requester 2 sends a 4-word packet → 1 word written, then fullp stalls. No timeout while stalled. The remaining 3 words are written as the reader drains the FIFO. Exactly 1 pkt_count increment.
- Requester 1 sends 2 non-EOP words, then drops valid → drop_pulse at exactly 16 cycles later, busy=0, pkt_count unchanged. A pending requester 3 is granted next.
- rstp asserted mid-packet (after 2 of 4 words) → next cycle busy=0, grant_id=0, pkt_count=0, no drop_pulse. After release, requester 0 has first priority.
- Single-word EOP packets from requesters 0 and 1 alternating → each writes one word, with one idle bubble between packets.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Producer lanes plus the FIFO write port, as seen by the packet write arbiter.
// master = arbiter side, slave = producers/FIFO side.
interface fifo_wr_arbiter_if #(
   parameter int NREQ    = 4,
   parameter int bitsize = 9
);
   logic [NREQ-1:0]         req_valid;
   logic [NREQ*bitsize-1:0] req_data;
   logic [NREQ-1:0]         req_ack;
   logic                    fifo_writep;
   logic [bitsize-1:0]      fifo_data_in;
   logic                    fifo_fullp;

   modport master (
      input  req_valid, req_data, fifo_fullp,
      output req_ack, fifo_writep, fifo_data_in
   );

   modport slave (
      output req_valid, req_data, fifo_fullp,
      input  req_ack, fifo_writep, fifo_data_in
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Packet-aware round-robin write arbiter: one producer owns the FIFO write port
// from grant until its EOP word is written or it idles for TIMEOUT cycles.
module fifo_wr_arbiter #(
   parameter int NREQ    = 4,
   parameter int bitsize = 9,
   parameter int TIMEOUT = 16
) (
   input  logic                    clk,
   input  logic                    rstp,
   fifo_wr_arbiter_if.master       bus,
   output logic [$clog2(NREQ)-1:0] grant_id,
   output logic                    busy,
   output logic                    drop_pulse,
   output logic [15:0]             pkt_count
);
   localparam int IDW  = $clog2(NREQ);
   localparam int CNTW = $clog2(TIMEOUT + 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t             state_reg;
   logic [IDW-1:0]     last_reg;
   logic [CNTW-1:0]    idle_cnt_reg;
   logic [bitsize-1:0] lane [NREQ];
   logic [IDW-1:0]     pick_next;
   logic [IDW-1:0]     scan_idx;
   logic               cur_valid;
   logic               accept;
   logic               cur_eop;

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
         assign lane[gi] = bus.req_data[gi*bitsize +: bitsize];
      end
   endgenerate

   assign cur_valid = bus.req_valid[grant_id];
   assign accept    = (state_reg == BUSY) && cur_valid && !bus.fifo_fullp;
   assign cur_eop   = lane[grant_id][bitsize-1];

   // Scan from farthest to nearest so the requester closest after last_reg wins.
   always_comb begin
      pick_next = '0;
      scan_idx  = '0;
      for (int k = NREQ; k >= 1; k--) begin
         scan_idx = IDW'((int'(last_reg) + k) % NREQ);
         if (bus.req_valid[scan_idx]) begin
            pick_next = scan_idx;
         end
      end
   end

   always_comb begin
      bus.req_ack      = '0;
      bus.fifo_writep  = accept;
      bus.fifo_data_in = '0;
      if (accept) begin
         bus.req_ack[grant_id] = 1'b1;
         bus.fifo_data_in      = lane[grant_id];
      end
   end

   always_ff @(posedge clk) begin
      if (rstp) begin
         state_reg    <= IDLE;
         last_reg     <= IDW'(NREQ - 1);
         idle_cnt_reg <= '0;
         grant_id     <= '0;
         busy         <= 1'b0;
         drop_pulse   <= 1'b0;
         pkt_count    <= '0;
      end else begin
         drop_pulse <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (|bus.req_valid) begin
                  grant_id     <= pick_next;
                  state_reg    <= BUSY;
                  busy         <= 1'b1;
                  idle_cnt_reg <= '0;
               end
            end
            BUSY: begin
               if (accept) begin
                  idle_cnt_reg <= '0;
                  if (cur_eop) begin
                     state_reg <= IDLE;
                     busy      <= 1'b0;
                     last_reg  <= grant_id;
                     pkt_count <= pkt_count + 16'd1;
                  end
               end else if (!cur_valid) begin
                  // A full-FIFO stall with valid held high falls through and holds the count.
                  if (idle_cnt_reg == CNTW'(TIMEOUT - 1)) begin
                     state_reg    <= IDLE;
                     busy         <= 1'b0;
                     last_reg     <= grant_id;
                     drop_pulse   <= 1'b1;
                     idle_cnt_reg <= '0;
                  end else begin
                     idle_cnt_reg <= idle_cnt_reg + CNTW'(1);
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table, directed packet
// scenarios and randomized traffic against a cycle-level reference model.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;
   localparam int NREQ    = 4;
   localparam int W       = 9;
   localparam int TIMEOUT = 16;
   localparam int IDW     = $clog2(NREQ);
   localparam int DEPTH   = 256;

   logic           clk = 1'b0;
   logic           rstp;
   logic [IDW-1:0] grant_id;
   logic           busy;
   logic           drop_pulse;
   logic [15:0]    pkt_count;

   fifo_wr_arbiter_if #(.NREQ(NREQ), .bitsize(W)) bus ();

   fifo_wr_arbiter #(.NREQ(NREQ), .bitsize(W), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .rstp       (rstp),
      .bus        (bus),
      .grant_id   (grant_id),
      .busy       (busy),
      .drop_pulse (drop_pulse),
      .pkt_count  (pkt_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // reference model state
   bit m_busy, m_drop, model_ok;
   int m_gid, m_last, m_idle, m_pkt;

   // values sampled mid-cycle
   logic [NREQ-1:0] s_v, s_ack;
   logic            s_wr, s_busy, s_drop;
   logic [W-1:0]    s_data;
   logic [IDW-1:0]  s_gid;
   logic [15:0]     s_pkt;

   // producer queues and the FIFO behind the arbiter
   logic [W-1:0] wq [NREQ][$];
   bit           hold [NREQ];
   logic [W-1:0] fq [$];

   typedef struct {
      logic [NREQ-1:0]   v;
      logic [NREQ*W-1:0] d;
      bit                full;
      bit                busy;
      int                gid;
      bit                wr;
      logic [W-1:0]      data;
      logic [NREQ-1:0]   ack;
      int                pkt;
      bit                drop;
   } vec_t;
   vec_t tbl [12];

   int exp_ord [5] = '{0, 1, 2, 3, 0};
   int ord [$];
   int n2, nwr, ndrop, k_c, d_c, g_c, busy_at_drop, pkt_at_drop, pv;
   logic [NREQ-1:0]   rv;
   logic [NREQ*W-1:0] rd;
   logic [W-1:0]      exp_fq [$];

   function automatic logic [NREQ*W-1:0] lanes4(input logic [W-1:0] l0, l1, l2, l3);
      return {l3, l2, l1, l0};
   endfunction

   function automatic vec_t mk(input logic [NREQ-1:0] v, input logic [NREQ*W-1:0] d,
                               input bit b, input int gid, input bit wr,
                               input logic [W-1:0] data, input logic [NREQ-1:0] ack, input int pkt);
      vec_t r;
      r.v = v; r.d = d; r.full = 1'b0;
      r.busy = b; r.gid = gid; r.wr = wr; r.data = data; r.ack = ack; r.pkt = pkt; r.drop = 1'b0;
      return r;
   endfunction

   // Arbitration rules applied once per clock edge, using plain integers.
   function automatic void model_step(input bit rst, input logic [NREQ-1:0] v,
                                      input logic [NREQ*W-1:0] d, input bit full);
      logic [W-1:0] w;
      if (rst) begin
         m_busy = 0; m_drop = 0; m_gid = 0; m_last = NREQ - 1; m_idle = 0; m_pkt = 0;
         return;
      end
      m_drop = 0;
      if (!m_busy) begin
         if (v != '0) begin
            for (int off = 1; off <= NREQ; off++) begin
               if (v[(m_last + off) % NREQ]) begin
                  m_gid = (m_last + off) % NREQ;
                  break;
               end
            end
            m_busy = 1;
            m_idle = 0;
         end
      end else if (v[m_gid] && !full) begin
         w = d[m_gid*W +: W];
         m_idle = 0;
         if (w[W-1]) begin
            m_busy = 0; m_last = m_gid; m_pkt = (m_pkt + 1) % 65536;
         end
      end else if (!v[m_gid]) begin
         m_idle++;
         if (m_idle == TIMEOUT) begin
            m_busy = 0; m_last = m_gid; m_drop = 1; m_idle = 0;
         end
      end
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic tick(input bit rst, input logic [NREQ-1:0] v, input logic [NREQ*W-1:0] d, input bit full);
      bit              exp_wr;
      logic [W-1:0]    exp_data;
      logic [NREQ-1:0] exp_ack;
      bit              ok;
      rstp             = rst;
      bus.req_valid    = v;
      bus.req_data     = d;
      bus.fifo_fullp   = full;
      #1;
      s_v = v; s_wr = bus.fifo_writep; s_data = bus.fifo_data_in; s_ack = bus.req_ack;
      s_busy = busy; s_gid = grant_id; s_drop = drop_pulse; s_pkt = pkt_count;
      if (model_ok) begin
         exp_wr = 0; exp_data = '0; exp_ack = '0;
         if (m_busy && v[m_gid] && !full) begin
            exp_wr = 1; exp_data = d[m_gid*W +: W]; exp_ack[m_gid] = 1'b1;
         end
         ok = (s_wr === exp_wr) && (s_data === exp_data) && (s_ack === exp_ack) &&
              (s_busy === m_busy) && (s_gid === IDW'(m_gid)) && (s_drop === m_drop) &&
              (s_pkt === 16'(m_pkt));
         n_checks++;
         if (!ok) begin
            n_fail++;
            $display("FAIL model cyc=%0d: got wr=%b data=%h ack=%b busy=%b gid=%0d drop=%b pkt=%0d; want wr=%0b data=%h ack=%b busy=%0b gid=%0d drop=%0b pkt=%0d",
                     cyc, s_wr, s_data, s_ack, s_busy, s_gid, s_drop, s_pkt,
                     exp_wr, exp_data, exp_ack, m_busy, m_gid, m_drop, m_pkt);
         end
      end
      if (s_wr === 1'b1) begin
         fq.push_back(s_data);
         if (s_data[W-1]) $display("cyc %0d: packet from req %0d done, eop word %h", cyc, s_gid, s_data);
      end
      if (s_drop === 1'b1) $display("cyc %0d: grant of req %0d dropped on timeout", cyc, s_gid);
      @(posedge clk);
      model_step(rst, v, d, full);
      if (rst) model_ok = 1;
      cyc++;
      #1;
   endtask

   task automatic env_tick(input bit rst, input bit rdp);
      logic [NREQ-1:0]   v;
      logic [NREQ*W-1:0] d;
      v = '0; d = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!hold[i] && wq[i].size() > 0) begin
            v[i] = 1'b1;
            d[i*W +: W] = wq[i][0];
         end
      end
      tick(rst, v, d, fq.size() >= DEPTH);
      for (int i = 0; i < NREQ; i++) begin
         if (s_ack[i] === 1'b1 && wq[i].size() > 0) void'(wq[i].pop_front());
      end
      if (rdp && fq.size() > 0) void'(fq.pop_front());
   endtask

   task automatic do_reset();
      for (int i = 0; i < NREQ; i++) begin
         wq[i].delete();
         hold[i] = 0;
      end
      tick(1'b1, '0, '0, 1'b0);
      fq.delete();
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---- vector table: 3-word packet from req 0, then alternating 1-word packets
      tbl[0]  = mk(4'b0001, lanes4(9'h012, 0, 0, 0), 0, 0, 0, 9'h000, 4'b0000, 0);
      tbl[1]  = mk(4'b0001, lanes4(9'h012, 0, 0, 0), 1, 0, 1, 9'h012, 4'b0001, 0);
      tbl[2]  = mk(4'b0001, lanes4(9'h034, 0, 0, 0), 1, 0, 1, 9'h034, 4'b0001, 0);
      tbl[3]  = mk(4'b0001, lanes4(9'h1AB, 0, 0, 0), 1, 0, 1, 9'h1AB, 4'b0001, 0);
      tbl[4]  = mk(4'b0000, lanes4(0, 0, 0, 0),      0, 0, 0, 9'h000, 4'b0000, 1);
      tbl[5]  = mk(4'b0011, lanes4(9'h101, 9'h102, 0, 0), 0, 0, 0, 9'h000, 4'b0000, 1);
      tbl[6]  = mk(4'b0011, lanes4(9'h101, 9'h102, 0, 0), 1, 1, 1, 9'h102, 4'b0010, 1);
      tbl[7]  = mk(4'b0011, lanes4(9'h101, 9'h102, 0, 0), 0, 1, 0, 9'h000, 4'b0000, 2);
      tbl[8]  = mk(4'b0011, lanes4(9'h101, 9'h102, 0, 0), 1, 0, 1, 9'h101, 4'b0001, 2);
      tbl[9]  = mk(4'b0011, lanes4(9'h101, 9'h102, 0, 0), 0, 0, 0, 9'h000, 4'b0000, 3);
      tbl[10] = mk(4'b0011, lanes4(9'h101, 9'h102, 0, 0), 1, 1, 1, 9'h102, 4'b0010, 3);
      tbl[11] = mk(4'b0000, lanes4(0, 0, 0, 0),      0, 1, 0, 9'h000, 4'b0000, 4);

      do_reset();
      for (int i = 0; i < 12; i++) begin
         tick(1'b0, tbl[i].v, tbl[i].d, tbl[i].full);
         n_checks++;
         if (!((s_busy === tbl[i].busy) && (s_gid === IDW'(tbl[i].gid)) && (s_wr === tbl[i].wr) &&
               (s_data === tbl[i].data) && (s_ack === tbl[i].ack) && (s_pkt === 16'(tbl[i].pkt)) &&
               (s_drop === tbl[i].drop))) begin
            n_fail++;
            $display("FAIL vec[%0d]: got busy=%b gid=%0d wr=%b data=%h ack=%b pkt=%0d drop=%b; want busy=%0b gid=%0d wr=%0b data=%h ack=%b pkt=%0d drop=%0b",
                     i, s_busy, s_gid, s_wr, s_data, s_ack, s_pkt, s_drop,
                     tbl[i].busy, tbl[i].gid, tbl[i].wr, tbl[i].data, tbl[i].ack, tbl[i].pkt, tbl[i].drop);
         end
         $display("vec %0d: valid=%b wr=%b data=%h busy=%b gid=%0d", i, tbl[i].v, s_wr, s_data, s_busy, s_gid);
      end
      exp_fq = '{9'h012, 9'h034, 9'h1AB, 9'h102, 9'h101, 9'h102};
      chk("vec_fifo_size", fq.size(), exp_fq.size());
      for (int k = 0; k < exp_fq.size(); k++)
         chk($sformatf("vec_fifo[%0d]", k), (k < fq.size()) ? int'(fq[k]) : -1, int'(exp_fq[k]));

      // ---- all four requesters with back-to-back 2-word packets
      do_reset();
      for (int i = 0; i < NREQ; i++)
         wq[i] = '{W'(i*16), W'(256 + i*16 + 1), W'(i*16 + 2), W'(256 + i*16 + 3)};
      ord.delete();
      for (int c = 0; c < 100 && ord.size() < 5; c++) begin
         env_tick(1'b0, 1'b0);
         if (s_wr === 1'b1 && s_data[W-1] === 1'b1) ord.push_back(int'(s_gid));
      end
      for (int k = 0; k < 5; k++)
         chk($sformatf("rr_order[%0d]", k), (k < ord.size()) ? ord[k] : -1, exp_ord[k]);
      env_tick(1'b0, 1'b0);
      chk("rr_pkt_count", int'(s_pkt), 5);
      exp_fq = '{9'h000, 9'h101, 9'h010, 9'h111, 9'h020, 9'h121, 9'h030, 9'h131, 9'h002, 9'h103};
      chk("rr_fifo_size", fq.size(), exp_fq.size());
      for (int k = 0; k < exp_fq.size(); k++)
         chk($sformatf("rr_fifo[%0d]", k), (k < fq.size()) ? int'(fq[k]) : -1, int'(exp_fq[k]));

      // ---- FIFO nearly full: one write, long stall, then drain
      do_reset();
      repeat (255) fq.push_back(9'h0AA);
      wq[2] = '{9'h020, 9'h021, 9'h022, 9'h123};
      nwr = 0; ndrop = 0;
      for (int c = 0; c < 40; c++) begin
         env_tick(1'b0, 1'b0);
         if (s_wr === 1'b1) nwr++;
         if (s_drop === 1'b1) ndrop++;
      end
      chk("full_stall_writes", nwr, 1);
      for (int c = 0; c < 60; c++) begin
         env_tick(1'b0, (c % 3) == 0);
         if (s_drop === 1'b1) ndrop++;
      end
      chk("full_no_timeout", ndrop, 0);
      chk("full_pkt_count", int'(s_pkt), 1);
      chk("full_words_left", wq[2].size(), 0);
      exp_fq = '{9'h020, 9'h021, 9'h022, 9'h123};
      for (int k = 0; k < 4; k++)
         chk($sformatf("full_tail[%0d]", k), int'(fq[fq.size() - 4 + k]), int'(exp_fq[k]));

      // ---- req 1 abandons its packet; req 3 waits behind it
      do_reset();
      wq[1] = '{9'h010, 9'h011};
      wq[3] = '{9'h130};
      k_c = -1; d_c = -1; g_c = -1; busy_at_drop = -1; pkt_at_drop = -1;
      for (int c = 0; c < 30; c++) begin
         env_tick(1'b0, 1'b0);
         if (k_c < 0 && s_busy === 1'b1 && s_gid === IDW'(1) && s_v[1] === 1'b0) k_c = c;
         if (d_c < 0 && s_drop === 1'b1) begin
            d_c = c; busy_at_drop = int'(s_busy); pkt_at_drop = int'(s_pkt);
         end
         if (d_c >= 0 && g_c < 0 && s_busy === 1'b1) g_c = int'(s_gid);
      end
      chk("timeout_latency", d_c - k_c, TIMEOUT);
      chk("timeout_busy", busy_at_drop, 0);
      chk("timeout_pkt_count", pkt_at_drop, 0);
      chk("timeout_next_grant", g_c, 3);

      // ---- reset in the middle of a 4-word packet
      do_reset();
      wq[2] = '{9'h1F0, 9'h021, 9'h022, 9'h023, 9'h124};
      wq[0] = '{9'h100};
      wq[3] = '{9'h130};
      hold[0] = 1; hold[3] = 1;
      n2 = 0;
      for (int c = 0; c < 20 && n2 < 3; c++) begin
         env_tick(1'b0, 1'b0);
         if (s_ack[2] === 1'b1) n2++;
      end
      env_tick(1'b1, 1'b0);
      chk("midrst_pkt_before", int'(s_pkt), 1);
      wq[2].delete();
      hold[0] = 0; hold[3] = 0;
      env_tick(1'b0, 1'b0);
      chk("midrst_busy", int'(s_busy), 0);
      chk("midrst_gid", int'(s_gid), 0);
      chk("midrst_pkt", int'(s_pkt), 0);
      chk("midrst_drop", int'(s_drop), 0);
      env_tick(1'b0, 1'b0);
      chk("midrst_first_grant", int'(s_gid), 0);
      chk("midrst_first_busy", int'(s_busy), 1);

      // ---- randomized traffic: busy phase, then sparse phase to provoke timeouts
      do_reset();
      ndrop = 0;
      for (int c = 0; c < 1200; c++) begin
         pv = (c < 800) ? 70 : 8;
         rv = '0; rd = '0;
         for (int i = 0; i < NREQ; i++) begin
            rv[i] = ($urandom_range(99) < pv);
            rd[i*W +: W] = {($urandom_range(3) == 0), 8'($urandom)};
         end
         tick($urandom_range(299) == 0, rv, rd, $urandom_range(3) == 0);
         if (s_drop === 1'b1) ndrop++;
      end
      $display("random traffic: 1200 cycles, %0d timeouts seen", ndrop);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
